adder_seq_ctrl: RTL and testbench

- Upstream control stage for the registered 16-bit operand/adder/result datapath (system_adder).
- Accepts operand pairs over a valid/ready handshake and drives the datapath's operand inputs and the three register enables (A, B, result) in the correct cycle order.
- Captures the carry-out at the right cycle and presents {sum, cout} downstream over a valid/ready handshake.
- One transaction in flight at a time.

---
 rtl/adder_seq_pkg.sv | 14 +
 rtl/adder_seq_if.sv | 43 ++++
 rtl/adder_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and default widths for the adder sequencing controller.
// Contents: FSM state enum plus the default operand and counter widths.
package adder_seq_pkg;

    localparam int unsigned W_DEFAULT     = 16;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_seq_if.sv
// Upstream operand handshake and downstream result handshake of adder_seq_ctrl.
//   in_valid/in_ready/in_a/in_b/in_cin : operand pair from upstream
//   out_valid/out_ready/out_sum/out_cout : result to downstream
//   out_ovf : signed overflow flag, only present when ADDER_SEQ_OVF_EN is defined
// slave modport is the controller side; master modport is the environment side.
interface adder_seq_if #(
    parameter int unsigned W = adder_seq_pkg::W_DEFAULT
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef ADDER_SEQ_OVF_EN
    logic         out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
`endif

endinterface

// File: rtl/adder_seq_ctrl.sv
// Control stage for the registered operand/adder/result datapath.
// Accepts one operand pair at a time, sequences the datapath register enables
// (A/B in IDLE, result in CALC), captures carry-out, and presents the result.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : operand and result handshakes
//   dp_d_a/dp_d_b    : operands to datapath
//   dp_en_a/b/result : datapath register enables
//   dp_cin           : carry-in to datapath
//   dp_result/dp_cout: registered sum and combinational carry from datapath
//   txn_count        : completed transactions, wraps
// Optional: ADDER_SEQ_OVF_EN adds bus.out_ovf (two's-complement overflow).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    adder_seq_if.slave       bus,
    output logic [W-1:0]     dp_d_a,
    output logic [W-1:0]     dp_d_b,
    output logic             dp_en_a,
    output logic             dp_en_b,
    output logic             dp_en_result,
    output logic             dp_cin,
    input  logic [W-1:0]     dp_result,
    input  logic             dp_cout,
    output logic [CNT_W-1:0] txn_count
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;
    logic              cin_q, cin_d;
    logic              cout_q, cout_d;
    logic              accept;

    // State and datapath-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            txn_count_q <= '0;
            cin_q       <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_count_q <= txn_count_d;
            cin_q       <= cin_d;
            cout_q      <= cout_d;
        end
    end

    // Next state, handshakes and datapath enables
    always_comb begin
        state_d       = state_q;
        txn_count_d   = txn_count_q;
        cin_d         = cin_q;
        cout_d        = cout_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        dp_en_a       = 1'b0;
        dp_en_b       = 1'b0;
        dp_en_result  = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                // Enables are gated by rst so a reset cycle never loads the datapath
                dp_en_a      = accept & ~rst;
                dp_en_b      = accept & ~rst;
                if (accept) begin
                    cin_d   = bus.in_cin;
                    state_d = CALC;
                end
            end
            CALC: begin
                dp_en_result = ~rst;
                // dp_cout is valid now: A/B are registered and dp_cin is cin_q
                cout_d       = dp_cout;
                state_d      = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    txn_count_d = txn_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dp_d_a       = bus.in_a;
    assign dp_d_b       = bus.in_b;
    assign dp_cin       = cin_q;
    assign bus.out_sum  = dp_result;
    assign bus.out_cout = cout_q;
    assign txn_count    = txn_count_q;

`ifdef ADDER_SEQ_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;

    // Operand sign bits, captured with the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (accept) begin
            a_msb_d = bus.in_a[W-1];
            b_msb_d = bus.in_b[W-1];
        end
    end

    // Overflow: same-sign operands producing a result of the other sign
    assign bus.out_ovf = bus.out_valid & (a_msb_q == b_msb_q) & (dp_result[W-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl with a behavioural model of the
// registered datapath (A, B, result registers; combinational carry-out).
// The DUT counter is built 2 bits wide so counter wrap is exercised.
module tb_adder_seq_ctrl;
    import adder_seq_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [W-1:0]     dp_d_a, dp_d_b, dp_result;
    logic             dp_en_a, dp_en_b, dp_en_result, dp_cin, dp_cout;
    logic [CNT_W-1:0] txn_count;

    adder_seq_if #(.W(W)) bus ();

    adder_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .dp_d_a       (dp_d_a),
        .dp_d_b       (dp_d_b),
        .dp_en_a      (dp_en_a),
        .dp_en_b      (dp_en_b),
        .dp_en_result (dp_en_result),
        .dp_cin       (dp_cin),
        .dp_result    (dp_result),
        .dp_cout      (dp_cout),
        .txn_count    (txn_count)
    );

    // Datapath model
    logic [W-1:0] ra, rb, rres;
    logic [W:0]   full_sum;
    assign full_sum  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, dp_cin};
    assign dp_cout   = full_sum[W];
    assign dp_result = rres;

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rres <= '0;
        end else begin
            if (dp_en_a)      ra   <= dp_d_a;
            if (dp_en_b)      rb   <= dp_d_b;
            if (dp_en_result) rres <= full_sum[W-1:0];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];
    logic [CNT_W-1:0] exp_cnt;
    int lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h5555;
        bus.in_b      = 16'h1111;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        exp_cnt       = '0;
        tick();
        tick();

        // In reset: no datapath loads even with in_valid high
        chk("rst_en_a", 32'(dp_en_a), 32'd0);
        chk("rst_en_b", 32'(dp_en_b), 32'd0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);

        // Reset while in CALC discards the transaction
        bus.in_a     = 16'h1111;
        bus.in_b     = 16'h2222;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
        chk("calc_en_result", 32'(dp_en_result), 32'd1);
        rst = 1'b1;
        #1;
        chk("calc_rst_en_result", 32'(dp_en_result), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_txn_count", 32'(txn_count), 32'd0);
        tick();
        chk("midrst_no_partial", 32'(bus.out_valid), 32'd0);

        // Table-driven transactions; counter wraps through 1,2,3,0,1,...
        for (int i = 0; i < 8; i++) begin
            bus.in_a     = vecs[i].a;
            bus.in_b     = vecs[i].b;
            bus.in_cin   = vecs[i].cin;
            bus.in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_sum", i), 32'(bus.out_sum), 32'(vecs[i].sum));
            chk($sformatf("v%0d_cout", i), 32'(bus.out_cout), 32'(vecs[i].cout));
`ifdef ADDER_SEQ_OVF_EN
            chk($sformatf("v%0d_ovf", i), 32'(bus.out_ovf), 32'(vecs[i].ovf));
`endif
            tick();
            exp_cnt = exp_cnt + 2'd1;
            chk($sformatf("v%0d_txn_count", i), 32'(txn_count), 32'(exp_cnt));
            chk($sformatf("v%0d_out_valid_low", i), 32'(bus.out_valid), 32'd0);
        end

        // Back-pressure: result held 5 cycles, new request ignored until release
        bus.out_ready = 1'b0;
        bus.in_a      = 16'h0F0F;
        bus.in_b      = 16'h0101;
        bus.in_cin    = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_a   = 16'h0002;
        bus.in_b   = 16'h0003;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_sum", k), 32'(bus.out_sum), 32'h1010);
            chk($sformatf("bp%0d_cout", k), 32'(bus.out_cout), 32'd0);
            chk($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp%0d_en_a", k), 32'(dp_en_a), 32'd0);
            chk($sformatf("bp%0d_txn_count", k), 32'(txn_count), 32'(exp_cnt));
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        tick();
        exp_cnt = exp_cnt + 2'd1;
        chk("bp_release_txn_count", 32'(txn_count), 32'(exp_cnt));
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(bus.in_ready), 32'd0);
        tick();
        chk("bp_next_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_sum", 32'(bus.out_sum), 32'h0005);
        tick();
        exp_cnt = exp_cnt + 2'd1;
        chk("bp_next_txn_count", 32'(txn_count), 32'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
